slave_bus_bridge: RTL and testbench

- Bridges SCC68070 accesses to the slave window (0x310000-0x31FFFF) onto the uc68hc05 port pins.
- Replaces the ad-hoc slave glue around the CPU/slave boundary: IRQ pulse to the microcontroller, DTACK edge detection, read-data latching.
- Adds a watchdog so a hung slave cannot stall the CPU forever.
- Sits between the CPU bus decode (upstream) and uc68hc05 (downstream).

---
 rtl/slave_bridge_pkg.sv | 14 +
 rtl/edge_detect_rise.sv | 20 ++
 rtl/slave_bus_bridge.sv | 144 ++++++++++++++
 tb/tb_slave_bus_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/slave_bridge_pkg.sv
// Shared types and constants for the SCC68070 to uc68hc05 slave bus bridge.
package slave_bridge_pkg;

  typedef enum logic [2:0] {IDLE, DELAY, IRQ, WAIT, RELEASE} slave_state_t;

  localparam logic [7:0] SLAVE_PORTA_IDLE = 8'hFF;
  localparam logic [7:0] SLAVE_CS_BASE    = 8'h31;

  // Byte handed to the uC on a write: low lane wins whenever it is strobed.
  function automatic logic [7:0] select_write_byte(input logic lds, input logic [15:0] din);
    return lds ? din[7:0] : din[15:8];
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered 1-bit rising-edge detector; the history register resets to RESET_VAL.
module edge_detect_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= RESET_VAL;
    else       d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/slave_bus_bridge.sv
// Bridges CPU accesses in the slave window onto the uc68hc05 port pins.
// Define SLAVE_TIMEOUT_EN to add a DTACK watchdog that raises bus_err.
module slave_bus_bridge
  import slave_bridge_pkg::*;
#(
  parameter int unsigned IRQ_DELAY = 20,
  parameter int unsigned IRQ_LEN   = 1,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic [1:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        bus_ack,
  output logic        bus_err,
  input  logic [7:0]  porta_out,
  input  logic        dtack_n,
  output logic [7:0]  porta_in,
  output logic [1:0]  portc_addr,
  output logic        portd_wr_n,
  output logic        slave_irq_n
);

  localparam int unsigned DLY_W = $clog2(IRQ_DELAY + 1);
  localparam int unsigned LEN_W = $clog2(IRQ_LEN + 1);

  slave_state_t     state;
  logic [DLY_W-1:0] dly_cnt;
  logic [LEN_W-1:0] irq_cnt;
  logic             dtack_rise_c;
  logic             strobe_c;

  assign strobe_c = uds | lds;

  // Completion point of a slave handshake is dtack_n returning high.
  edge_detect_rise #(.RESET_VAL(1'b1)) u_dtack_edge (
    .clk    (clk),
    .reset  (reset),
    .d      (dtack_n),
    .rise_c (dtack_rise_c)
  );

`ifdef SLAVE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expire_c;

  // Fires on the WAIT cycle whose decrement would reach zero.
  assign tmo_expire_c = (tmo_cnt <= TMO_W'(1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      irq_cnt     <= '0;
      dout        <= '0;
      bus_ack     <= 1'b0;
      bus_err     <= 1'b0;
      porta_in    <= SLAVE_PORTA_IDLE;
      portc_addr  <= 2'b11;
      portd_wr_n  <= 1'b1;
      slave_irq_n <= 1'b1;
`ifdef SLAVE_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      bus_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs && strobe_c) begin
            portc_addr <= addr;
            portd_wr_n <= ~write_strobe;
            if (write_strobe) porta_in <= select_write_byte(lds, din);
            dly_cnt    <= DLY_W'(IRQ_DELAY);
            state      <= DELAY;
          end
        end
        DELAY: begin
          if (!cs) begin
            porta_in <= SLAVE_PORTA_IDLE;
            state    <= IDLE;
          end else if (dly_cnt == '0) begin
            slave_irq_n <= 1'b0;
            irq_cnt     <= LEN_W'(IRQ_LEN - 1);
            state       <= IRQ;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        IRQ: begin
          if (!cs) begin
            slave_irq_n <= 1'b1;
            porta_in    <= SLAVE_PORTA_IDLE;
            state       <= IDLE;
          end else if (irq_cnt == '0) begin
            slave_irq_n <= 1'b1;
            state       <= WAIT;
`ifdef SLAVE_TIMEOUT_EN
            tmo_cnt     <= TMO_W'(TIMEOUT);
`endif
          end else begin
            irq_cnt <= irq_cnt - LEN_W'(1);
          end
        end
        WAIT: begin
          if (!cs) begin
            porta_in <= SLAVE_PORTA_IDLE;
            state    <= IDLE;
          end else if (dtack_rise_c) begin
            if (portd_wr_n) dout <= {porta_out, porta_out};
            bus_ack <= 1'b1;
            state   <= RELEASE;
`ifdef SLAVE_TIMEOUT_EN
          end else if (tmo_expire_c) begin
            bus_err <= 1'b1;
            state   <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
`endif
          end
        end
        RELEASE: begin
          // Hold off until the CPU ends its cycle so one access triggers once.
          if (!cs) begin
            porta_in <= SLAVE_PORTA_IDLE;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_bus_bridge.sv
// Self-checking bench for slave_bus_bridge: timeline model plus directed accesses.
module tb_slave_bus_bridge;

  localparam int D = 20;
  localparam int L = 1;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, uds, lds, write_strobe;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        bus_ack, bus_err;
  logic [7:0]  porta_out;
  logic        dtack_n;
  logic [7:0]  porta_in;
  logic [1:0]  portc_addr;
  logic        portd_wr_n;
  logic        slave_irq_n;

  int vectors = 0;
  int miscompares = 0;

  slave_bus_bridge #(.IRQ_DELAY(D), .IRQ_LEN(L), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .cs(cs), .uds(uds), .lds(lds),
    .write_strobe(write_strobe), .addr(addr), .din(din), .dout(dout),
    .bus_ack(bus_ack), .bus_err(bus_err), .porta_out(porta_out),
    .dtack_n(dtack_n), .porta_in(porta_in), .portc_addr(portc_addr),
    .portd_wr_n(portd_wr_n), .slave_irq_n(slave_irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs derived from the cycle offset since the access was accepted.
  int          cyc, m_t0, n_c;
  logic        m_active, m_done, m_dprev, rise_m;
  logic [15:0] e_dout;
  logic        e_ack, e_err, e_wr_n, e_irq_n;
  logic [7:0]  e_porta;
  logic [1:0]  e_addr;

  assign n_c    = cyc - m_t0;
  assign rise_m = dtack_n & ~m_dprev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; m_t0 <= 0; m_active <= 1'b0; m_done <= 1'b0; m_dprev <= 1'b1;
      e_dout <= 16'h0; e_ack <= 1'b0; e_err <= 1'b0; e_porta <= 8'hFF;
      e_addr <= 2'd3; e_wr_n <= 1'b1; e_irq_n <= 1'b1;
    end else begin
      cyc     <= cyc + 1;
      m_dprev <= dtack_n;
      e_ack   <= 1'b0;
      e_err   <= 1'b0;
      if (!m_active) begin
        if (cs && (uds || lds)) begin
          m_active <= 1'b1; m_done <= 1'b0; m_t0 <= cyc;
          e_addr <= addr; e_wr_n <= !write_strobe;
          if (write_strobe) e_porta <= lds ? din[7:0] : din[15:8];
        end
      end else if (m_done) begin
        if (!cs) begin m_active <= 1'b0; e_porta <= 8'hFF; end
      end else if (!cs) begin
        m_active <= 1'b0; e_irq_n <= 1'b1; e_porta <= 8'hFF;
      end else begin
        e_irq_n <= !(n_c >= D + 1 && n_c < D + 1 + L);
        if (n_c >= D + L + 2 && rise_m) begin
          e_ack <= 1'b1; m_done <= 1'b1;
          if (e_wr_n) e_dout <= {porta_out, porta_out};
        end
`ifdef SLAVE_TIMEOUT_EN
        else if (n_c == D + L + 1 + T) begin
          e_err <= 1'b1; m_done <= 1'b1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("dout", 32'(dout), 32'(e_dout));
      chk("bus_ack", 32'(bus_ack), 32'(e_ack));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("porta_in", 32'(porta_in), 32'(e_porta));
      chk("portc_addr", 32'(portc_addr), 32'(e_addr));
      chk("portd_wr_n", 32'(portd_wr_n), 32'(e_wr_n));
      chk("slave_irq_n", 32'(slave_irq_n), 32'(e_irq_n));
      chk("ack_err_excl", 32'(bus_ack & bus_err), 32'h0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".dout"}, 32'(dout), 32'h0);
    chk({tag, ".bus_ack"}, 32'(bus_ack), 32'h0);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, ".porta_in"}, 32'(porta_in), 32'hFF);
    chk({tag, ".portc_addr"}, 32'(portc_addr), 32'h3);
    chk({tag, ".portd_wr_n"}, 32'(portd_wr_n), 32'h1);
    chk({tag, ".slave_irq_n"}, 32'(slave_irq_n), 32'h1);
  endtask

  // One CPU access; i is the index of the clock edge just observed (0 = accept edge).
  task automatic access(input logic [1:0] a, input logic we, input logic u, input logic l,
                        input logic [15:0] d, input logic [7:0] pa, input int dt_at,
                        input int abort_at, input int len,
                        output int irq_first, output int irq_lows, output int ack_cnt,
                        output int ack_at, output int err_cnt, output int err_at,
                        output logic [7:0] pa_mid);
    irq_first = -1; irq_lows = 0; ack_cnt = 0; ack_at = -1;
    err_cnt = 0; err_at = -1; pa_mid = 8'h00;
    addr = a; write_strobe = we; uds = u; lds = l; din = d; porta_out = pa; cs = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (!slave_irq_n) begin irq_lows++; if (irq_first < 0) irq_first = i; end
      if (bus_ack) begin ack_cnt++; ack_at = i; end
      if (bus_err) begin err_cnt++; err_at = i; end
      if (i == 5) pa_mid = porta_in;
      if (i == dt_at) dtack_n = 1'b0;
      if (i == dt_at + 3) dtack_n = 1'b1;
      if (i == abort_at) cs = 1'b0;
    end
    cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at;
  logic [7:0] pa_mid;

  initial begin
    reset = 1'b1; cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    addr = 2'd0; din = 16'h0; porta_out = 8'h00; dtack_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    #2 reset = 1'b0;
    @(negedge clk);

    // Read at addr 2, slave answers with DTACK low on edges 40..42.
    access(2'd2, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h5A, 39, -1, 60,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("rd.irq_first", 32'(irq_first), 32'd21);
    chk("rd.irq_lows", 32'(irq_lows), 32'd1);
    chk("rd.ack_cnt", 32'(ack_cnt), 32'd1);
    chk("rd.ack_at", 32'(ack_at), 32'd43);
    chk("rd.err_cnt", 32'(err_cnt), 32'd0);
    chk("rd.dout", 32'(dout), 32'h5A5A);
    chk("rd.portc_addr", 32'(portc_addr), 32'd2);
    chk("rd.portd_wr_n", 32'(portd_wr_n), 32'd1);

    // Word write: low byte goes to the uC; dout keeps the previous read data.
    access(2'd1, 1'b1, 1'b1, 1'b1, 16'h1234, 8'h00, 39, -1, 60,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("wr.porta_mid", 32'(pa_mid), 32'h34);
    chk("wr.irq_first", 32'(irq_first), 32'd21);
    chk("wr.ack_cnt", 32'(ack_cnt), 32'd1);
    chk("wr.portd_wr_n", 32'(portd_wr_n), 32'd0);
    chk("wr.dout_held", 32'(dout), 32'h5A5A);
    chk("wr.porta_idle", 32'(porta_in), 32'hFF);

    // Upper-only write.
    access(2'd0, 1'b1, 1'b1, 1'b0, 16'hAB00, 8'h00, 39, -1, 60,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("wru.porta_mid", 32'(pa_mid), 32'hAB);
    chk("wru.ack_cnt", 32'(ack_cnt), 32'd1);

    // DTACK toggled only during DELAY.
`ifdef SLAVE_TIMEOUT_EN
    access(2'd3, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h11, 5, -1, 140,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("tmo.err_cnt", 32'(err_cnt), 32'd1);
    chk("tmo.err_at", 32'(err_at), 32'd122);
`else
    access(2'd3, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h11, 5, -1, 60,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("tmo.err_cnt", 32'(err_cnt), 32'd0);
`endif
    chk("tmo.ack_cnt", 32'(ack_cnt), 32'd0);

    // cs dropped while the IRQ is asserted.
    access(2'd2, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h22, 30, 21, 60,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("abt.irq_first", 32'(irq_first), 32'd21);
    chk("abt.irq_lows", 32'(irq_lows), 32'd1);
    chk("abt.ack_cnt", 32'(ack_cnt), 32'd0);

    // Asynchronous reset while waiting for the slave.
    addr = 2'd1; write_strobe = 1'b1; lds = 1'b1; uds = 1'b0; din = 16'h00C5; cs = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst.pre_porta", 32'(porta_in), 32'hC5);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    cs = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);

    // Recovery read after reset.
    access(2'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hC3, 25, -1, 40,
           irq_first, irq_lows, ack_cnt, ack_at, err_cnt, err_at, pa_mid);
    chk("rec.irq_first", 32'(irq_first), 32'd21);
    chk("rec.ack_at", 32'(ack_at), 32'd29);
    chk("rec.dout", 32'(dout), 32'hC3C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
